// File: rtl/byte_sus_pkg.sv
// byte_sus_pkg: shared constants and width-select helpers for the n-lane byte striper.
package byte_sus_pkg;
  localparam logic [31:0] PAD_SYM = 32'hF7F7_F7F7;
  localparam int W_X1 = 0;
  localparam int W_X2 = 1;
  localparam int W_X4 = 2;
  function automatic int unsigned clamp_log2(input int unsigned sel, input int unsigned max_log2);
    return sel > max_log2 ? max_log2 : sel;
  endfunction
endpackage

// File: rtl/stripe_lane_ctr.sv
// stripe_lane_ctr: group index, latched lane width and emit/fill decode for the striper.
module stripe_lane_ctr
  import byte_sus_pkg::*;
#(
  parameter int LOG2_LANES = 2,
  parameter int SW = $clog2(LOG2_LANES + 1),
  parameter int IW = LOG2_LANES > 0 ? LOG2_LANES : 1,
  parameter int CW = LOG2_LANES + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid_i,
  input  logic          flush_i,
  input  logic [SW-1:0] width_sel_i,
  output logic          emit_o,
  output logic [IW-1:0] idx_o,
  output logic [CW-1:0] act_n_o,
  output logic [CW-1:0] fill_o,
  output logic          busy_o
);
  logic [IW-1:0] idx_q, idx_d;
  logic [SW-1:0] act_q, act_d;
  logic busy_q, last;
  // The width is sampled by the first word of a group and then frozen until the group ends.
  always_comb begin
    act_d = (valid_i && idx_q == '0) ? SW'(clamp_log2(int'(width_sel_i), LOG2_LANES)) : act_q;
    act_n_o = CW'(1) << act_d;
    last = valid_i && (CW'(idx_q) + CW'(1) == act_n_o);
    emit_o = last || (flush_i && (valid_i || idx_q != '0));
    fill_o = last ? act_n_o : CW'(idx_q) + CW'(valid_i);
    idx_d = emit_o ? '0 : idx_q + IW'(valid_i);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      idx_q <= '0;
      act_q <= SW'(LOG2_LANES);
      busy_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      act_q <= act_d;
      busy_q <= idx_d != '0;
    end
  assign idx_o = idx_q;
  assign busy_o = busy_q;
endmodule

// File: rtl/byte_striper_nlane.sv
// byte_striper_nlane: stripes a word stream round-robin over a runtime-selectable
// number of lanes, emitting whole groups with PAD fill on flush.
module byte_striper_nlane
  import byte_sus_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LOG2_LANES = 2,
  parameter logic [WIDTH-1:0] PAD = WIDTH'(PAD_SYM)
) (
  input  logic                                clk_2f,
  input  logic                                reset,
  input  logic [WIDTH-1:0]                    data_in,
  input  logic                                valid_in,
  input  logic [$clog2(LOG2_LANES+1)-1:0]     width_sel,
  input  logic                                flush,
  output logic [(1<<LOG2_LANES)*WIDTH-1:0]    lane_data,
  output logic [(1<<LOG2_LANES)-1:0]          lane_valid,
  output logic                                busy
);
  localparam int LANES = 1 << LOG2_LANES;
  localparam int SW = $clog2(LOG2_LANES + 1);
  localparam int IW = LOG2_LANES > 0 ? LOG2_LANES : 1;
  localparam int CW = LOG2_LANES + 1;
  logic [WIDTH-1:0] stage_q [LANES];
  logic [WIDTH-1:0] stage_d [LANES];
  logic [LANES*WIDTH-1:0] lane_data_q, lane_data_d;
  logic [LANES-1:0] lane_valid_q, lane_valid_d;
  logic emit;
  logic [IW-1:0] idx;
  logic [CW-1:0] act_n, fill;
  stripe_lane_ctr #(.LOG2_LANES(LOG2_LANES), .SW(SW), .IW(IW), .CW(CW)) u_ctr (
    .clk(clk_2f),
    .rst(reset),
    .valid_i(valid_in),
    .flush_i(flush),
    .width_sel_i(width_sel),
    .emit_o(emit),
    .idx_o(idx),
    .act_n_o(act_n),
    .fill_o(fill),
    .busy_o(busy)
  );
  // stage_d already holds the completing word, so it reaches its lane in the same emit.
  always_comb begin
    stage_d = stage_q;
    lane_data_d = lane_data_q;
    lane_valid_d = '0;
    if (valid_in) stage_d[idx] = data_in;
    for (int i = 0; i < LANES; i++) begin
      lane_valid_d[i] = emit && CW'(i) < act_n;
      if (emit)
        lane_data_d[i*WIDTH +: WIDTH] = CW'(i) >= act_n ? '0 : CW'(i) < fill ? stage_d[i] : PAD;
    end
  end
  always_ff @(posedge clk_2f or posedge reset)
    if (reset) begin
      stage_q <= '{default: '0};
      lane_data_q <= '0;
      lane_valid_q <= '0;
    end else begin
      stage_q <= stage_d;
      lane_data_q <= lane_data_d;
      lane_valid_q <= lane_valid_d;
    end
  assign lane_data = lane_data_q;
  assign lane_valid = lane_valid_q;
endmodule

// File: tb/tb_byte_striper_nlane.sv
// tb_byte_striper_nlane: directed and randomized checks against a group-level reference model.
module tb_byte_striper_nlane;
  localparam logic [31:0] PADW = 32'hF7F7_F7F7;
  logic clk_2f = 1'b0;
  logic reset, valid_in, flush, busy;
  logic [31:0] data_in;
  logic [1:0] width_sel;
  logic [127:0] lane_data;
  logic [3:0] lane_valid;
  int checks = 0;
  int failures = 0;
  logic [31:0] m_stage [4];
  logic [31:0] m_data [4];
  logic [3:0] m_valid;
  int m_idx, m_cnt;

  always #5 clk_2f = ~clk_2f;

  byte_striper_nlane dut (
    .clk_2f(clk_2f),
    .reset(reset),
    .data_in(data_in),
    .valid_in(valid_in),
    .width_sel(width_sel),
    .flush(flush),
    .lane_data(lane_data),
    .lane_valid(lane_valid),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_idx = 0;
    m_cnt = 4;
    m_valid = '0;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = '0;
      m_stage[i] = '0;
    end
  endtask

  task automatic m_emit(input int filled);
    for (int i = 0; i < 4; i++)
      m_data[i] = i < m_cnt ? (i < filled ? m_stage[i] : PADW) : 32'h0;
    m_valid = 4'((1 << m_cnt) - 1);
  endtask

  // Group-level view: collect words into a group of m_cnt; emit on completion or flush.
  task automatic m_edge();
    m_valid = '0;
    if (valid_in) begin
      if (m_idx == 0) m_cnt = 1 << (width_sel > 2'd2 ? 2 : int'(width_sel));
      m_stage[m_idx] = data_in;
      m_idx++;
      if (m_idx == m_cnt) begin
        m_emit(m_cnt);
        m_idx = 0;
      end else if (flush) begin
        m_emit(m_idx);
        m_idx = 0;
      end
    end else if (flush && m_idx != 0) begin
      m_emit(m_idx);
      m_idx = 0;
    end
  endtask

  task automatic compare_all();
    check("lane_data", lane_data, {m_data[3], m_data[2], m_data[1], m_data[0]});
    check("lane_valid", 128'(lane_valid), 128'(m_valid));
    check("busy", 128'(busy), 128'(m_idx != 0));
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic f, input logic [1:0] s);
    valid_in = v;
    data_in = d;
    flush = f;
    width_sel = s;
    @(posedge clk_2f);
    m_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    m_reset();
    check("rst_data", lane_data, 128'h0);
    check("rst_valid", 128'(lane_valid), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    #2 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    valid_in = 1'b0;
    flush = 1'b0;
    data_in = '0;
    width_sel = 2'd2;
    m_reset();
    #3;
    check("rst_data", lane_data, 128'h0);
    check("rst_valid", 128'(lane_valid), 128'h0);
    check("rst_busy", 128'(busy), 128'h0);
    #9 reset = 1'b0;
    // x4 full group, then hold
    cyc(1, 32'hFFFF_FFFF, 0, 2);
    cyc(1, 32'hEEEE_EEEE, 0, 2);
    cyc(1, 32'hDDDD_DDDD, 0, 2);
    cyc(1, 32'hCCCC_CCCC, 0, 2);
    check("t1_valid", 128'(lane_valid), 128'hF);
    check("t1_data", lane_data, {32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_FFFF});
    cyc(0, 32'h0, 0, 2);
    check("t1_strobe_end", 128'(lane_valid), 128'h0);
    check("t1_hold", 128'(lane_data[31:0]), 128'hFFFF_FFFF);
    // x2 groups
    cyc(1, 32'hFFFF_FFFF, 0, 1);
    cyc(1, 32'hEEEE_EEEE, 0, 1);
    check("t2_valid_a", 128'(lane_valid), 128'h3);
    check("t2_data_a", lane_data, {64'h0, 32'hEEEE_EEEE, 32'hFFFF_FFFF});
    cyc(1, 32'hDDDD_DDDD, 0, 1);
    check("t2_gap", 128'(lane_valid), 128'h0);
    cyc(1, 32'hCCCC_CCCC, 0, 1);
    check("t2_data_b", lane_data, {64'h0, 32'hCCCC_CCCC, 32'hDDDD_DDDD});
    // x4 with a 3-cycle gap
    cyc(1, 32'hFFFF_FFFF, 0, 2);
    cyc(1, 32'hEEEE_EEEE, 0, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 32'h1234_5678, 0, 2);
      check("t3_busy", 128'(busy), 128'h1);
    end
    cyc(1, 32'hDDDD_DDDD, 0, 2);
    cyc(1, 32'hCCCC_CCCC, 0, 2);
    check("t3_data", lane_data, {32'hCCCC_CCCC, 32'hDDDD_DDDD, 32'hEEEE_EEEE, 32'hFFFF_FFFF});
    // flush partial x4 group, then flush while idle
    cyc(1, 32'hFFFF_FFFF, 0, 2);
    cyc(1, 32'hEEEE_EEEE, 0, 2);
    cyc(1, 32'hDDDD_DDDD, 0, 2);
    cyc(0, 32'h0, 1, 2);
    check("t4_valid", 128'(lane_valid), 128'hF);
    check("t4_pad", 128'(lane_data[127:96]), 128'(PADW));
    check("t4_busy", 128'(busy), 128'h0);
    cyc(0, 32'h0, 1, 2);
    check("t4_idle_flush", 128'(lane_valid), 128'h0);
    // width change mid-group is ignored until the boundary
    cyc(1, 32'h1111_1111, 0, 2);
    cyc(1, 32'h2222_2222, 0, 0);
    cyc(1, 32'h3333_3333, 0, 0);
    cyc(1, 32'h4444_4444, 0, 0);
    check("t5_x4", 128'(lane_valid), 128'hF);
    cyc(1, 32'h5555_5555, 0, 0);
    check("t5_x1", 128'(lane_valid), 128'h1);
    check("t5_x1_data", lane_data, {96'h0, 32'h5555_5555});
    // async reset mid-group discards staged words
    cyc(1, 32'hFFFF_FFFF, 0, 2);
    cyc(1, 32'hEEEE_EEEE, 0, 2);
    do_reset();
    cyc(1, 32'hA0A0_A0A0, 0, 2);
    cyc(1, 32'hA1A1_A1A1, 0, 2);
    cyc(1, 32'hA2A2_A2A2, 0, 2);
    cyc(1, 32'hA3A3_A3A3, 0, 2);
    check("t6_data", lane_data, {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0});
    // flush together with a word at the start of an x4 group pads from lane 1
    cyc(1, 32'hBBBB_BBBB, 1, 2);
    check("flush_valid_pad", lane_data, {PADW, PADW, PADW, 32'hBBBB_BBBB});
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      cyc(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 5) == 0),
          2'($urandom_range(0, 3)));
      if ($urandom_range(0, 399) == 0) do_reset();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
